led_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.

---
 rtl/led_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_led_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment
// display. One external led_decode instance is shared by all digits: dh selects
// the nibble, and seg_data comes back to be registered onto seg. Each digit slot
// begins with a blank interval to suppress ghosting. New values wait for the
// frame boundary so that a frame is never drawn with a mix of old and new digits.
module led_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_en,
    output logic [3:0]            dh,
    input  logic [7:0]            seg_data,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shown_val_q, shown_val_d;
    logic [DIGITS-1:0]     shown_dp_q, shown_dp_d;
    logic [4*DIGITS-1:0]   cap_val_q, cap_val_d;
    logic [DIGITS-1:0]     cap_dp_q, cap_dp_d;
    logic                  pending_q, pending_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  cnt_end, idx_end, boundary;
    logic                  cur_dp, lz_blank, hi_zero;
    logic [DIGITS-1:0]     an_sel;

    // Per-digit selection: nibble for the decoder, dp bit, anode pattern and
    // leading-zero test (digit idx and every higher digit are zero).
    always_comb begin
        dh       = 4'd0;
        cur_dp   = 1'b0;
        an_sel   = '1;
        lz_blank = 1'b0;
        hi_zero  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dh        = shown_val_q[4*i +: 4];
                cur_dp    = shown_dp_q[i];
                an_sel[i] = 1'b0;
            end
        end
        // Walk down from the top digit; digit 0 is never considered.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero & (shown_val_q[4*i +: 4] == 4'd0);
            if (idx_q == IW'(i)) lz_blank = lz_en & hi_zero;
        end
    end

    // Slot/digit counters, output decode and frame-boundary value handoff.
    always_comb begin
        cnt_end  = (cnt_q == CW'(PRESCALE - 1));
        idx_end  = (idx_q == IW'(DIGITS - 1));
        boundary = cnt_end & idx_end;

        cnt_d = cnt_end ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_end) idx_d = idx_end ? '0 : idx_q + IW'(1);

        // Outputs lag the (cnt, idx) that produced them by one cycle.
        if (cnt_q < CW'(BLANK) || lz_blank) begin
            an_d  = '1;
            seg_d = 8'hFF;
        end else begin
            an_d  = an_sel;
            seg_d = {~cur_dp, seg_data[6:0]};
        end
        frame_tick_d = boundary;

        shown_val_d = shown_val_q;
        shown_dp_d  = shown_dp_q;
        cap_val_d   = cap_val_q;
        cap_dp_d    = cap_dp_q;
        pending_d   = pending_q;
        if (boundary) begin
            // A load on the boundary cycle itself bypasses the capture.
            if (load) begin
                shown_val_d = value;
                shown_dp_d  = dp_mask;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                shown_val_d = cap_val_q;
                shown_dp_d  = cap_dp_q;
                pending_d   = 1'b0;
            end
        end else if (load) begin
            cap_val_d = value;
            cap_dp_d  = dp_mask;
            pending_d = 1'b1;
        end
    end

    // State and registered outputs; reset also discards any waiting capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shown_val_q  <= '0;
            shown_dp_q   <= '0;
            cap_val_q    <= '0;
            cap_dp_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shown_val_q  <= shown_val_d;
            shown_dp_q   <= shown_dp_d;
            cap_val_q    <= cap_val_d;
            cap_dp_q     <= cap_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: table of per-digit expectations, hand-written
// corner sequences, and random traffic, all checked every cycle against a
// reference model that derives slot position from elapsed cycles.
module tb_led_scan_ctrl;
    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst, load, lz_en, junk7;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  dh, an;
    logic [7:0]  seg_data, seg;
    logic        frame_tick, pending;

    always #5 clk = ~clk;

    led_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
        .lz_en(lz_en), .dh(dh), .seg_data(seg_data), .seg(seg), .an(an),
        .frame_tick(frame_tick), .pending(pending)
    );

    // Stand-in for led_decode: active-low {a,b,c,d,e,f,g}; bit7 is junk.
    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01; 4'h1: return 7'h4F; 4'h2: return 7'h12; 4'h3: return 7'h06;
            4'h4: return 7'h4C; 4'h5: return 7'h24; 4'h6: return 7'h20; 4'h7: return 7'h0F;
            4'h8: return 7'h00; 4'h9: return 7'h04; 4'hA: return 7'h08; 4'hB: return 7'h60;
            4'hC: return 7'h31; 4'hD: return 7'h42; 4'hE: return 7'h30; default: return 7'h38;
        endcase
    endfunction
    assign seg_data = {junk7, dec7(dh)};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: t = cycles since reset release; slot/digit follow from t.
    int         t;
    logic [3:0] m_shown [D];
    logic [3:0] m_cap   [D];
    logic [3:0] m_dp, m_capdp;
    logic       m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_dp = '0; m_capdp = '0; m_pend = 1'b0;
        for (int j = 0; j < D; j++) begin m_shown[j] = '0; m_cap[j] = '0; end
    endtask

    // One clock: predict from pre-edge inputs/model, advance, compare at edge+1.
    task automatic step();
        int c, ix;
        logic allz, blank, bnd;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        c  = t % P;
        ix = (t / P) % D;
        allz = 1'b1;
        for (int j = ix; j < D; j++) if (m_shown[j] != 4'd0) allz = 1'b0;
        blank = (c < B) || (lz_en && ix > 0 && allz);
        e_an  = blank ? 4'hF : ~(4'b0001 << ix);
        e_seg = blank ? 8'hFF : {~m_dp[ix], dec7(m_shown[ix])};
        bnd   = (ix == D - 1) && (c == P - 1);
        if (bnd) begin
            if (load) begin
                for (int j = 0; j < D; j++) m_shown[j] = value[4*j +: 4];
                m_dp = dp_mask; m_pend = 1'b0;
            end else if (m_pend) begin
                for (int j = 0; j < D; j++) m_shown[j] = m_cap[j];
                m_dp = m_capdp; m_pend = 1'b0;
            end
        end else if (load) begin
            for (int j = 0; j < D; j++) m_cap[j] = value[4*j +: 4];
            m_capdp = dp_mask; m_pend = 1'b1;
        end
        t++;
        @(posedge clk); #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("frame_tick", frame_tick, bnd);
        chk("pending", pending, m_pend);
        chk("dh", dh, m_shown[(t / P) % D]);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Advance until the next edge is the frame boundary (bounded by one frame).
    task automatic to_boundary();
        for (int k = 0; k < P * D; k++) begin
            if ((t % P == P - 1) && ((t / P) % D == D - 1)) break;
            step();
        end
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic        lz;
        int          dig;
        logic [7:0]  eseg;
        logic [3:0]  ean;
    } vec_t;
    vec_t vt [12];

    initial begin
        int last;
        vt[0]  = '{16'h1234, 4'b0000, 1'b0, 0, 8'hCC, 4'hE};
        vt[1]  = '{16'h1234, 4'b0000, 1'b0, 3, 8'hCF, 4'h7};
        vt[2]  = '{16'h1234, 4'b0000, 1'b0, 1, 8'h86, 4'hD};
        vt[3]  = '{16'h0008, 4'b0010, 1'b0, 1, 8'h01, 4'hD};
        vt[4]  = '{16'h0008, 4'b0010, 1'b0, 0, 8'h80, 4'hE};
        vt[5]  = '{16'h0008, 4'b0010, 1'b0, 2, 8'h81, 4'hB};
        vt[6]  = '{16'h0050, 4'b0000, 1'b1, 3, 8'hFF, 4'hF};
        vt[7]  = '{16'h0050, 4'b0000, 1'b1, 2, 8'hFF, 4'hF};
        vt[8]  = '{16'h0050, 4'b0000, 1'b1, 1, 8'hA4, 4'hD};
        vt[9]  = '{16'h0050, 4'b0000, 1'b1, 0, 8'h81, 4'hE};
        vt[10] = '{16'h0000, 4'b0000, 1'b1, 0, 8'h81, 4'hE};
        vt[11] = '{16'h0000, 4'b0000, 1'b1, 1, 8'hFF, 4'hF};

        rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; lz_en = 1'b0; junk7 = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_pending", pending, 1'b0);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_dh", dh, 4'h0);
        rst = 1'b0;

        // Table: load at a boundary, then look at one digit's SHOW phase.
        foreach (vt[i]) begin
            to_boundary();
            value = vt[i].v; dp_mask = vt[i].dp; lz_en = vt[i].lz; load = 1'b1;
            step();
            load = 1'b0;
            run(P * vt[i].dig + B + 2);
            chk("tbl_seg", seg, vt[i].eseg);
            chk("tbl_an", an, vt[i].ean);
        end
        lz_en = 1'b0;

        // frame_tick period is one full frame.
        last = -1;
        for (int k = 0; k < 3 * P * D; k++) begin
            step();
            if (frame_tick) begin
                if (last >= 0) chk("tick_period", k - last, P * D);
                last = k;
            end
        end

        // No tearing: two loads mid-frame, last wins at the boundary.
        to_boundary(); step(); run(5);
        value = 16'hAAAA; load = 1'b1; step();
        value = 16'hBBBB; step();
        load = 1'b0;
        chk("tear_pending", pending, 1'b1);
        to_boundary(); step();
        chk("tear_pending_clr", pending, 1'b0);
        run(B + 2);
        chk("tear_seg_B", seg, 8'hE0);

        // Load exactly on the boundary cycle.
        to_boundary();
        value = 16'h1111; load = 1'b1; step();
        load = 1'b0;
        chk("bnd_tick", frame_tick, 1'b1);
        chk("bnd_pending", pending, 1'b0);
        run(B + 2);
        chk("bnd_seg_1", seg, 8'hCF);

        // Reset in the middle of a SHOW phase with a capture waiting.
        to_boundary(); step(); run(B + 2);
        value = 16'h5555; load = 1'b1; step();
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_pending", pending, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step();
        chk("post_rst_dh", dh, 4'h0);
        chk("post_rst_an", an, 4'hF);
        run(P * D + 4);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            load    = ($urandom_range(0, 15) == 0);
            value   = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            dp_mask = 4'($urandom);
            junk7   = 1'($urandom);
            if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
